// File: rtl/dmac_mi_chan_arb_pkg.sv
// Shared types and helpers for the per-master-interface channel arbiter.
package dmac_mi_chan_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSREQ = 2'b01,
    ST_OWN    = 2'b10
  } arb_state_e;

  localparam int PRI_W_DEF = 3;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmac_prio_rr_pick.sv
// Combinational winner select: highest priority, ties broken round-robin after rr_ptr.
module dmac_prio_rr_pick
  import dmac_mi_chan_arb_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int PRI_W  = PRI_W_DEF,
  parameter int IDX_W  = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0]       eff_req,
  input  logic [NUM_CH*PRI_W-1:0] ch_prior,
  input  logic [IDX_W-1:0]        rr_ptr,
  output logic [IDX_W-1:0]        win_idx,
  output logic                    any_req
);

  always_comb begin
    logic             found;
    logic [PRI_W-1:0] best_pri;
    int               idx;
    found    = 1'b0;
    best_pri = '0;
    win_idx  = '0;
    idx      = 0;
    // Scanning in round-robin order with a strict compare keeps the first tied requester.
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_CH;
      if (eff_req[idx] && (!found || ch_prior[idx*PRI_W +: PRI_W] > best_pri)) begin
        found    = 1'b1;
        best_pri = ch_prior[idx*PRI_W +: PRI_W];
        win_idx  = IDX_W'(idx);
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/dmac_mi_chan_arb.sv
// Per-MI channel arbiter: picks a channel, requests the AHB bus and holds the
// grant until the burst completes, with optional per-block channel lock.
module dmac_mi_chan_arb
  import dmac_mi_chan_arb_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int PRI_W  = PRI_W_DEF,
  parameter int IDX_W  = clog2_min1(NUM_CH)
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [NUM_CH-1:0]       req_mi,
  input  logic [NUM_CH*PRI_W-1:0] ch_prior,
  input  logic [NUM_CH-1:0]       ch_lock,
  input  logic [NUM_CH-1:0]       block_done,
  input  logic                    xfer_done,
  input  logic                    hgrant,
  output logic [NUM_CH-1:0]       grant_mi,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    grant_vld,
  output logic [NUM_CH-1:0]       mask_lck_ch,
  output logic                    hbusreq,
  output logic                    hlock
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  win_idx_q, win_idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  lock_ch_q, lock_ch_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              lock_active_q, lock_active_d;
  logic              hbusreq_q, hbusreq_d;
  logic              grant_vld_q, grant_vld_d;
  logic [NUM_CH-1:0] grant_mi_q, grant_mi_d;
  logic [NUM_CH-1:0] eff_req;
  logic [IDX_W-1:0]  pick_idx;
  logic              any_req;

  assign mask_lck_ch = lock_active_q ? ~(NUM_CH'(1) << lock_ch_q) : '0;
  assign eff_req     = req_mi & ~mask_lck_ch;

  dmac_prio_rr_pick #(
    .NUM_CH (NUM_CH),
    .PRI_W  (PRI_W),
    .IDX_W  (IDX_W)
  ) u_pick (
    .eff_req  (eff_req),
    .ch_prior (ch_prior),
    .rr_ptr   (rr_ptr_q),
    .win_idx  (pick_idx),
    .any_req  (any_req)
  );

  always_comb begin
    state_d       = state_q;
    win_idx_d     = win_idx_q;
    rr_ptr_d      = rr_ptr_q;
    lock_ch_d     = lock_ch_q;
    lock_active_d = lock_active_q;
    hbusreq_d     = hbusreq_q;
    grant_mi_d    = grant_mi_q;
    grant_idx_d   = grant_idx_q;
    grant_vld_d   = grant_vld_q;

    if (lock_active_q && block_done[lock_ch_q]) lock_active_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          win_idx_d = pick_idx;
          hbusreq_d = 1'b1;
          state_d   = ST_BUSREQ;
        end
      end
      ST_BUSREQ: begin
        if (!req_mi[win_idx_q]) begin
          hbusreq_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (hgrant) begin
          grant_mi_d  = NUM_CH'(1) << win_idx_q;
          grant_idx_d = win_idx_q;
          grant_vld_d = 1'b1;
          rr_ptr_d    = win_idx_q;
          state_d     = ST_OWN;
          if (ch_lock[win_idx_q]) begin
            lock_active_d = 1'b1;
            lock_ch_d     = win_idx_q;
          end
        end
      end
      ST_OWN: begin
        if (xfer_done) begin
          grant_mi_d  = '0;
          grant_vld_d = 1'b0;
          // A held lock goes straight back to the same channel without arbitration.
          if (lock_active_q && !block_done[lock_ch_q]) begin
            win_idx_d = lock_ch_q;
            state_d   = ST_BUSREQ;
          end else begin
            hbusreq_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (!hgrant) begin
          grant_mi_d  = '0;
          grant_vld_d = 1'b0;
          state_d     = ST_BUSREQ;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        hbusreq_d   = 1'b0;
        grant_mi_d  = '0;
        grant_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q       <= ST_IDLE;
      win_idx_q     <= '0;
      rr_ptr_q      <= IDX_W'(NUM_CH - 1);
      lock_ch_q     <= '0;
      lock_active_q <= 1'b0;
      hbusreq_q     <= 1'b0;
      grant_mi_q    <= '0;
      grant_idx_q   <= '0;
      grant_vld_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_idx_q     <= win_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_ch_q     <= lock_ch_d;
      lock_active_q <= lock_active_d;
      hbusreq_q     <= hbusreq_d;
      grant_mi_q    <= grant_mi_d;
      grant_idx_q   <= grant_idx_d;
      grant_vld_q   <= grant_vld_d;
    end
  end

  assign grant_mi  = grant_mi_q;
  assign grant_idx = grant_idx_q;
  assign grant_vld = grant_vld_q;
  assign hbusreq   = hbusreq_q;
  assign hlock     = lock_active_q;

endmodule

// File: doc/dmac_mi_chan_arb.md
Name: dmac_mi_chan_arb

Overview:
- Per-master-interface channel arbiter. Sits directly downstream of the per-MI request mask stage and consumes its masked channel request vector (req_mi).
- Picks one channel by programmed priority, with round-robin tie-break. Requests the AHB bus and holds the grant until the channel's burst completes.
- Produces grant_mi and mask_lck_ch, which feed back to the mask stage, plus hbusreq/hlock toward the AHB master port.

Parameters:
- NUM_CH, `DMAH_NUM_PER, number of channel state-machine request lines.
- PRI_W, 3, width of each channel priority field.
- IDX_W, clog2(NUM_CH) (min 1), width of the grant index.

Ports:
- hclk  input  1  clock.
- hresetn  input  1  asynchronous active-low reset.
- req_mi  input  NUM_CH  per-channel requests already masked to this master interface.
- ch_prior  input  NUM_CH*PRI_W  channel i priority in bits [i*PRI_W +: PRI_W]; higher value wins.
- ch_lock  input  NUM_CH  channel requests bus/arbiter lock for its current block.
- block_done  input  NUM_CH  one-cycle pulse at the end of channel i's block.
- xfer_done  input  1  granted channel finished its current burst (single-cycle pulse).
- hgrant  input  1  AHB bus grant for this master interface.
- grant_mi  output  NUM_CH  one-hot registered grant, or zero.
- grant_idx  output  IDX_W  index of the granted channel; valid when grant_vld=1.
- grant_vld  output  1  grant_mi is non-zero.
- mask_lck_ch  output  NUM_CH  channels masked while a lock is held.
- hbusreq  output  1  AHB bus request.
- hlock  output  1  AHB locked-transfer indication.

Behaviour:
- Reset (async, hresetn=0):
  - State=IDLE.
  - All outputs 0.
  - rr_ptr=NUM_CH-1, so channel 0 wins the first tie.
  - lock_active=0, lock_ch=0.
- Effective request: eff_req = req_mi & ~mask_lck_ch.
- Winner selection (combinational, from eff_req):
  - Highest ch_prior among requesters wins.
  - Ties resolve round-robin: first requester at index rr_ptr+1, rr_ptr+2, ... (wrapping modulo NUM_CH).
- IDLE:
  - If eff_req != 0: latch winner into win_idx, set hbusreq=1 next cycle, go to BUSREQ.
  - Otherwise stay in IDLE.
- BUSREQ:
  - hbusreq=1.
  - If req_mi[win_idx]=0: deassert hbusreq and go to IDLE (re-arbitrate next cycle).
  - Else if hgrant=1: go to OWN, with grant_mi=onehot(win_idx), grant_idx=win_idx, grant_vld=1 from the next cycle. Update rr_ptr=win_idx.
  - The winner is not re-evaluated while in BUSREQ, even if a higher-priority request arrives.
- OWN:
  - grant_mi held stable; hbusreq stays 1.
  - If hgrant drops before xfer_done: clear grant_mi and go to BUSREQ with win_idx unchanged.
  - On xfer_done=1: clear grant_mi next cycle.
    - If lock_active and block_done[lock_ch]=0: go to BUSREQ with win_idx=lock_ch, with no re-arbitration.
    - Otherwise go to IDLE.
  - If xfer_done and hgrant loss coincide, xfer_done takes precedence.
- Lock:
  - Entering OWN with ch_lock[win_idx]=1 sets lock_active=1 and lock_ch=win_idx.
  - While lock_active=1: mask_lck_ch = ~onehot(lock_ch) and hlock=1.
  - block_done[lock_ch]=1 clears lock_active next cycle, in any state.
  - block_done for other channels is ignored.
  - When not locked, mask_lck_ch=0 and hlock=0.
- Grant latency: a request in IDLE with hgrant already high gives grant_vld 2 cycles after the request edge (IDLE→BUSREQ→OWN).
- grant_mi is always one-hot or zero; it is never asserted outside OWN.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'b00, BUSREQ=2'b01, OWN=2'b10);
  - PRI_W default;
  - the clog2 function used for IDX_W.
- Sub-module dmac_prio_rr_pick: purely combinational. Takes eff_req, ch_prior and rr_ptr; returns win_idx and any_req. The arbiter FSM, rr_ptr and lock registers live in the top module.

Test Plan:
1. Single request, hgrant=1, NUM_CH=8: req_mi=8'h04 → hbusreq=1 at cycle+1, grant_mi=8'h04, grant_idx=2, grant_vld=1 at cycle+2. xfer_done → grant_mi=0 the next cycle and state returns to IDLE.
2. Priority: req_mi=8'h09, ch_prior ch0=1, ch3=5 → channel 3 granted first. After its xfer_done, channel 0 is granted.
3. Round-robin tie: req_mi=8'h0F held, all priorities equal → grant order 0,1,2,3,0 across successive xfer_done pulses.
4. Lock: ch_lock[1]=1 and channel 1 granted → mask_lck_ch=8'hFD, hlock=1. Repeated xfer_done re-grants channel 1 only, even with req_mi=8'hFF. block_done[1] → mask_lck_ch=0 and normal arbitration resumes.
5. Winner withdraws: in BUSREQ with hgrant=0, req_mi[win]=0 → hbusreq=0, back to IDLE, and the next requester is picked.
6. Reset mid-OWN under lock: hresetn=0 → grant_mi, mask_lck_ch, hbusreq and hlock go to 0 immediately. After release, channel 0 wins a full-vector tie.
